seq_player: RTL and testbench

//  Reads the FPGA sequence register (64-bit, 16 x 4-bit one-hot entries) and plays
//  the stored entries out on the 4 LEDs, oldest first, paced by the selected game tick
//  (one-cycle enable derived from the CLKHZ rate). Sits between REG_FPGA and the LED pins;
//  the control FSM starts it after each new round and waits for done before user entry.

---
 rtl/seq_player_if.sv | 28 ++
 rtl/seq_player.sv | 159 +++++++++++++++
 tb/tb_seq_player.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_player_if.sv
// Bundle of playback control, sequence data and LED/status outputs for seq_player.
interface seq_player_if #(
    parameter int unsigned N_ENTRIES = 16,
    parameter int unsigned ENTRY_W   = 4,
    parameter int unsigned LEN_W     = 5
) ();

    logic                           tick;
    logic                           start;
    logic                           abort;
    logic [LEN_W-1:0]               len;
    logic [N_ENTRIES*ENTRY_W-1:0]   seq;
    logic [ENTRY_W-1:0]             leds;
    logic                           busy;
    logic                           done;
    logic [LEN_W-1:0]               idx;

    modport master (
        output tick, start, abort, len, seq,
        input  leds, busy, done, idx
    );

    modport slave (
        input  tick, start, abort, len, seq,
        output leds, busy, done, idx
    );

endinterface

// File: rtl/seq_player.sv
// Plays the latched sequence register out on the LEDs, oldest entry first, one entry per
// SHOW_TICKS ticks. Define SEQ_PLAYER_GAP_EN to insert a dark gap between entries.
module seq_player #(
    parameter int unsigned N_ENTRIES  = 16,
    parameter int unsigned ENTRY_W    = 4,
    parameter int unsigned LEN_W      = 5,
    parameter int unsigned SHOW_TICKS = 2,
    parameter int unsigned GAP_TICKS  = 1
) (
    input  logic          CLOCK_50,
    input  logic          R_n,
    seq_player_if.slave   bus
);

    localparam int unsigned SeqW     = N_ENTRIES * ENTRY_W;
    localparam int unsigned MaxTicks = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int unsigned CntW     = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;

    localparam logic [LEN_W-1:0] LenMax   = LEN_W'(N_ENTRIES);
    localparam logic [CntW-1:0]  ShowLast = CntW'(SHOW_TICKS - 1);
`ifdef SEQ_PLAYER_GAP_EN
    localparam logic [CntW-1:0]  GapLast  = CntW'(GAP_TICKS - 1);
`endif

    typedef enum logic [1:0] {StIdle, StShow, StGap, StFin} state_e;

    state_e              state_q;
    logic [SeqW-1:0]     seq_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    k_q;
    logic [CntW-1:0]     cnt_q;
    logic [ENTRY_W-1:0]  leds_q;
    logic                busy_q;
    logic                done_q;
    logic [LEN_W-1:0]    idx_q;

    logic [LEN_W-1:0]    len_clamped;
    logic [LEN_W-1:0]    k_nxt;

    // Entry k of a len-entry sequence sits at nibble (N_ENTRIES - len + k).
    function automatic logic [ENTRY_W-1:0] entry_at(input logic [SeqW-1:0]  s,
                                                    input logic [LEN_W-1:0] l,
                                                    input logic [LEN_W-1:0] k);
        int unsigned pos;
        pos = N_ENTRIES - 32'(l) + 32'(k);
        return s[pos*ENTRY_W +: ENTRY_W];
    endfunction

    always_comb begin
        len_clamped = (bus.len > LenMax) ? LenMax : bus.len;
        k_nxt       = k_q + LEN_W'(1);
    end

    always_ff @(posedge CLOCK_50 or negedge R_n) begin
        if (!R_n) begin
            state_q <= StIdle;
            seq_q   <= '0;
            len_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            leds_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // abort beats a coincident start; a coincident tick is not counted
                    if (bus.start && !bus.abort) begin
                        seq_q  <= bus.seq;
                        len_q  <= len_clamped;
                        k_q    <= '0;
                        cnt_q  <= '0;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                        if (len_clamped == '0) begin
                            state_q <= StFin;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StShow;
                            leds_q  <= entry_at(bus.seq, len_clamped, '0);
                        end
                    end
                end
                StShow: begin
                    if (bus.abort) begin
                        state_q <= StIdle;
                        leds_q  <= '0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (bus.tick) begin
                        if (cnt_q == ShowLast) begin
                            cnt_q <= '0;
                            idx_q <= k_nxt;
                            if (k_nxt == len_q) begin
                                state_q <= StFin;
                                leds_q  <= '0;
                                done_q  <= 1'b1;
                            end else begin
`ifdef SEQ_PLAYER_GAP_EN
                                state_q <= StGap;
                                leds_q  <= '0;
`else
                                k_q    <= k_nxt;
                                leds_q <= entry_at(seq_q, len_q, k_nxt);
`endif
                            end
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StGap: begin
`ifdef SEQ_PLAYER_GAP_EN
                    if (bus.abort) begin
                        state_q <= StIdle;
                        leds_q  <= '0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (bus.tick) begin
                        if (cnt_q == GapLast) begin
                            cnt_q   <= '0;
                            state_q <= StShow;
                            k_q     <= k_nxt;
                            leds_q  <= entry_at(seq_q, len_q, k_nxt);
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
`else
                    state_q <= StIdle;
                    leds_q  <= '0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
`endif
                end
                StFin: begin
                    state_q <= StIdle;
                    leds_q  <= '0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    leds_q  <= '0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.leds = leds_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.idx  = idx_q;

endmodule

// File: tb/tb_seq_player.sv
// Self-checking bench for seq_player: directed scenarios plus random traffic, compared each
// cycle against a phase-list model of the playback schedule.
module tb_seq_player;

    localparam int NEnt       = 16;
    localparam int EntW       = 4;
    localparam int LenW       = 5;
    localparam int ShowTicks  = 2;
    localparam int GapTicks   = 1;

    logic clk = 1'b0;
    logic r_n;
    always #5 clk = ~clk;

    seq_player_if #(.N_ENTRIES(NEnt), .ENTRY_W(EntW), .LEN_W(LenW)) bus ();

    seq_player #(
        .N_ENTRIES (NEnt),
        .ENTRY_W   (EntW),
        .LEN_W     (LenW),
        .SHOW_TICKS(ShowTicks),
        .GAP_TICKS (GapTicks)
    ) dut (
        .CLOCK_50(clk),
        .R_n     (r_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    // Playback is a list of phases: each shows a LED value for a number of ticks.
    typedef struct {
        logic [3:0] leds;
        int         ticks;
        bit         is_show;
    } phase_t;

    phase_t     ph[$];
    bit         m_active, m_fin;
    int         m_p, m_cnt;
    logic [3:0] e_leds;
    logic       e_busy, e_done;
    logic [4:0] e_idx;

    task automatic model_reset();
        ph.delete();
        m_active = 0;
        m_fin    = 0;
        m_p      = 0;
        m_cnt    = 0;
        e_leds   = '0;
        e_busy   = 1'b0;
        e_done   = 1'b0;
        e_idx    = '0;
    endtask

    task automatic build_phases(input logic [63:0] s, input logic [4:0] l);
        int n;
        phase_t p;
        n = (int'(l) > NEnt) ? NEnt : int'(l);
        ph.delete();
        for (int k = 0; k < n; k++) begin
            p.leds    = s[(NEnt - n + k)*4 +: 4];
            p.ticks   = ShowTicks;
            p.is_show = 1;
            ph.push_back(p);
`ifdef SEQ_PLAYER_GAP_EN
            if (k < n - 1) begin
                p.leds    = '0;
                p.ticks   = GapTicks;
                p.is_show = 0;
                ph.push_back(p);
            end
`endif
        end
    endtask

    task automatic model_step();
        if (m_fin) begin
            m_fin  = 0;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_leds = '0;
        end else if (!m_active) begin
            if (bus.start && !bus.abort) begin
                build_phases(bus.seq, bus.len);
                e_idx  = '0;
                e_busy = 1'b1;
                if (ph.size() == 0) begin
                    m_fin  = 1;
                    e_done = 1'b1;
                end else begin
                    m_active = 1;
                    m_p      = 0;
                    m_cnt    = 0;
                    e_leds   = ph[0].leds;
                end
            end
        end else if (bus.abort) begin
            m_active = 0;
            e_busy   = 1'b0;
            e_leds   = '0;
        end else if (bus.tick) begin
            m_cnt++;
            if (m_cnt == ph[m_p].ticks) begin
                m_cnt = 0;
                if (ph[m_p].is_show) e_idx = e_idx + 5'd1;
                m_p++;
                if (m_p == ph.size()) begin
                    m_active = 0;
                    m_fin    = 1;
                    e_done   = 1'b1;
                    e_leds   = '0;
                end else begin
                    e_leds = ph[m_p].leds;
                end
            end
        end
    endtask

    task automatic check();
        tests++;
        assert (bus.leds === e_leds) else begin
            fails++;
            $error("FAIL leds @%0t: got %b expected %b", $time, bus.leds, e_leds);
        end
        tests++;
        assert (bus.busy === e_busy) else begin
            fails++;
            $error("FAIL busy @%0t: got %b expected %b", $time, bus.busy, e_busy);
        end
        tests++;
        assert (bus.done === e_done) else begin
            fails++;
            $error("FAIL done @%0t: got %b expected %b", $time, bus.done, e_done);
        end
        tests++;
        assert (bus.idx === e_idx) else begin
            fails++;
            $error("FAIL idx @%0t: got %0d expected %0d", $time, bus.idx, e_idx);
        end
    endtask

    // Inputs change 1ns after an edge, so they are stable at the next edge.
    task automatic step(input bit t, input bit s, input bit a);
        bus.tick  = t;
        bus.start = s;
        bus.abort = a;
        @(posedge clk);
        if (r_n) model_step();
        #1;
        check();
    endtask

    task automatic do_reset();
        #1 r_n = 1'b0;
        #1 model_reset();
        check();
        @(posedge clk);
        #1 check();
        #1 r_n = 1'b1;
    endtask

    initial begin
        r_n       = 1'b0;
        bus.tick  = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.len   = '0;
        bus.seq   = '0;
        model_reset();
        #2 check();
        @(posedge clk);
        #3 r_n = 1'b1;

        // Three one-hot entries, ticks every other cycle, then every cycle
        bus.seq = {12'b0100_0010_0001, 52'd0};
        bus.len = 5'd3;
        step(0, 1, 0);
        for (int i = 0; i < 24; i++) step(i % 2 == 0, 0, 0);
        step(0, 1, 0);
        for (int i = 0; i < 14; i++) step(1, 0, 0);

        // Empty sequence: straight to the done cycle
        bus.len = 5'd0;
        step(0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0);

        // Start with coincident tick, second start mid-play, seq/len changed mid-play
        bus.seq = {$urandom, $urandom};
        bus.len = 5'd5;
        step(1, 1, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        bus.seq = ~bus.seq;
        bus.len = 5'd2;
        for (int i = 0; i < 40; i++) step($urandom_range(0, 1) == 1, 0, 0);

        // Reset in the middle of a three-entry playback
        bus.seq = {$urandom, $urandom};
        bus.len = 5'd3;
        step(0, 1, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 0);

        // Sixteen entries, abort after idx reaches 5, then restart from nibble 0
        bus.seq = {16{4'b1000}};
        bus.len = 5'd16;
        step(0, 1, 0);
        for (int i = 0; i < 200 && e_idx != 5'd5; i++) step($urandom_range(0, 1) == 1, 0, 0);
        step(1, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        bus.seq = {$urandom, $urandom};
        bus.len = 5'd16;
        step(0, 1, 1);
        step(1, 0, 0);
        step(0, 1, 0);
        for (int i = 0; i < 80; i++) step(1, 0, 0);

        // Clamp: len above N_ENTRIES
        bus.seq = {$urandom, $urandom};
        bus.len = 5'd27;
        step(0, 1, 0);
        for (int i = 0; i < 60; i++) step(1, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.seq = {$urandom, $urandom};
                bus.len = 5'($urandom_range(0, 20));
            end
            if ($urandom_range(0, 499) == 0) do_reset();
            step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 59) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
